// File: rtl/c17_stress_ctrl.sv
// Stress-then-sweep test controller for a small combinational CUT (c17 class).
// Holds an optional stress vector, then walks the vector/golden memories and counts mismatches.
//
// state  | meaning
// IDLE   | waiting for start; results and cut_in held
// STRESS | stress_vec held on the CUT for stress_len cycles
// FETCH  | vec_addr stable, memory read in flight
// APPLY  | vector driven on the CUT, settling for SETTLE cycles
// SAMPLE | cut_out compared with golden data
// DONE   | one-cycle completion pulse
module c17_stress_ctrl #(
    parameter int VEC_WIDTH  = 5,
    parameter int OUT_WIDTH  = 2,
    parameter int VEC_LENGTH = 16,
    parameter int SETTLE     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          mode,
    input  logic [VEC_WIDTH-1:0]          stress_vec,
    input  logic [15:0]                   stress_len,
    output logic [$clog2(VEC_LENGTH)-1:0] vec_addr,
    input  logic [VEC_WIDTH-1:0]          vec_rdata,
    input  logic [OUT_WIDTH-1:0]          gold_rdata,
    output logic [VEC_WIDTH-1:0]          cut_in,
    input  logic [OUT_WIDTH-1:0]          cut_out,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   err_count,
    output logic [$clog2(VEC_LENGTH)-1:0] first_err_addr,
    output logic                          err_flag
);

    localparam int AW = $clog2(VEC_LENGTH);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(VEC_LENGTH - 1);
    localparam logic [15:0]   SETTLE_LOAD = 16'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STRESS,
        S_FETCH,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [VEC_WIDTH-1:0] cut_in_q, cut_in_d;
    logic [AW-1:0]        vec_addr_q, vec_addr_d;
    logic [15:0]          err_count_q, err_count_d;
    logic                 err_flag_q, err_flag_d;
    logic [AW-1:0]        first_err_addr_q, first_err_addr_d;
    logic                 mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            cut_in_q         <= '0;
            vec_addr_q       <= '0;
            err_count_q      <= '0;
            err_flag_q       <= 1'b0;
            first_err_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cut_in_q         <= cut_in_d;
            vec_addr_q       <= vec_addr_d;
            err_count_q      <= err_count_d;
            err_flag_q       <= err_flag_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign mismatch = (state_q == S_SAMPLE) && (cut_out != gold_rdata);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        cut_in_d         = cut_in_q;
        vec_addr_d       = vec_addr_q;
        err_count_d      = err_count_q;
        err_flag_d       = err_flag_q;
        first_err_addr_d = first_err_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    err_count_d      = '0;
                    err_flag_d       = 1'b0;
                    first_err_addr_d = '0;
                    vec_addr_d       = '0;
                    if (mode && (stress_len != 16'd0)) begin
                        state_d  = S_STRESS;
                        cut_in_d = stress_vec;
                        cnt_d    = stress_len;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_STRESS: begin
                // counter holds the cycles still to spend here, including this one
                if (cnt_q <= 16'd1) begin
                    state_d    = S_FETCH;
                    cnt_d      = '0;
                    vec_addr_d = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_FETCH: begin
                state_d  = S_APPLY;
                cut_in_d = vec_rdata;
                cnt_d    = SETTLE_LOAD;
            end
            S_APPLY: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_SAMPLE: begin
                if (vec_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    vec_addr_d = vec_addr_q + 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // result update is independent of abort so a mismatch seen in the abort cycle still counts
        if (mismatch) begin
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
            if (!err_flag_q) begin
                err_flag_d       = 1'b1;
                first_err_addr_d = vec_addr_q;
            end
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            cut_in_d   = '0;
            cnt_d      = '0;
            vec_addr_d = vec_addr_q;
        end
    end

    assign vec_addr       = vec_addr_q;
    assign cut_in         = cut_in_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign err_count      = err_count_q;
    assign err_flag       = err_flag_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_c17_stress_ctrl.sv
// Bench for c17_stress_ctrl: c17 CUT model plus vector/golden memories with selectable corruption.
// Expected results come from a run-level model: corrupted entries, stress length and per-vector period.
module tb_c17_stress_ctrl;

    localparam int VW = 5;
    localparam int OW = 2;
    localparam int VL = 16;
    localparam int ST = 2;
    localparam int P  = ST + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic [VW-1:0] stress_vec = '0;
    logic [15:0]   stress_len = '0;
    logic [3:0]    vec_addr;
    logic [VW-1:0] vec_rdata;
    logic [OW-1:0] gold_rdata;
    logic [VW-1:0] cut_in;
    logic [OW-1:0] cut_out;
    logic          busy;
    logic          done;
    logic [15:0]   err_count;
    logic [3:0]    first_err_addr;
    logic          err_flag;

    logic [VW-1:0] vmem [VL];
    logic [OW-1:0] gmem [VL];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] c17(input logic [4:0] x);
        logic n10, n11, n16, n19;
        n10 = ~(x[0] & x[2]);
        n11 = ~(x[2] & x[3]);
        n16 = ~(x[1] & n11);
        n19 = ~(n11 & x[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    assign cut_out    = c17(cut_in);
    assign vec_rdata  = vmem[vec_addr];
    assign gold_rdata = gmem[vec_addr];

    c17_stress_ctrl #(
        .VEC_WIDTH (VW),
        .OUT_WIDTH (OW),
        .VEC_LENGTH(VL),
        .SETTLE    (ST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .mode          (mode),
        .stress_vec    (stress_vec),
        .stress_len    (stress_len),
        .vec_addr      (vec_addr),
        .vec_rdata     (vec_rdata),
        .gold_rdata    (gold_rdata),
        .cut_in        (cut_in),
        .cut_out       (cut_out),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .err_flag      (err_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [15:0] mask);
        for (int i = 0; i < VL; i++) begin
            vmem[i] = VW'($urandom_range(1, 31));
            gmem[i] = c17(vmem[i]) ^ (mask[i] ? OW'($urandom_range(1, 3)) : OW'(0));
        end
    endtask

    task automatic pulse_start(input logic m, input logic [15:0] len, input logic [4:0] sv);
        @(negedge clk);
        mode = m; stress_len = len; stress_vec = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic m, input logic [15:0] len,
                             input logic [4:0] sv, input logic [15:0] mask, input int poke,
                             input int exp_err, input int exp_first, input logic exp_flag,
                             input int exp_lat);
        int l_eff, lat, dones, bad_s, bad_a, j;
        l_eff = (m && len != 16'd0) ? int'(len) : 0;
        load_mem(mask);
        pulse_start(m, len, sv);
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        check({tag, " err_cleared"}, 32'(err_count), 32'd0);
        lat = 0; dones = 0; bad_s = 0; bad_a = 0;
        if (l_eff > 0 && cut_in !== sv) bad_s++;
        for (int k = 1; k <= exp_lat + 20; k++) begin
            @(posedge clk); #1;
            start = (k == poke);
            if (k <= l_eff && cut_in !== sv) bad_s++;
            if (k > l_eff) begin
                j = k - l_eff - 1;
                if (j % P == 0 && j / P < VL)
                    if (cut_in !== vmem[j / P] || int'(vec_addr) != j / P) bad_a++;
            end
            if (done) begin
                dones++;
                if (lat == 0) lat = k;
            end
            if (lat != 0 && !busy) break;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " done_pulses"}, 32'(dones), 32'd1);
        check({tag, " stress_hold_errs"}, 32'(bad_s), 32'd0);
        check({tag, " apply_errs"}, 32'(bad_a), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
        check({tag, " err_flag"}, 32'(err_flag), 32'(exp_flag));
        check({tag, " first_err_addr"}, 32'(first_err_addr), 32'(exp_first));
        repeat (3) @(posedge clk);
        #1;
        check({tag, " idle_cut_in_held"}, 32'(cut_in), 32'(vmem[VL-1]));
        check({tag, " err_held"}, 32'(err_count), 32'(exp_err));
    endtask

    typedef struct {
        logic        m;
        logic [15:0] len;
        logic [4:0]  sv;
        logic [15:0] mask;
        int          poke;
        int          exp_err;
        int          exp_first;
        logic        exp_flag;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   found, dones, e_err, e_first;
        logic [15:0] r_mask, r_len;
        logic r_m;

        tbl[0] = '{1'b0, 16'd0,   5'b00000, 16'h0000, -1, 0,  0,  1'b0, 64};
        tbl[1] = '{1'b0, 16'd0,   5'b00000, 16'h0208, -1, 2,  3,  1'b1, 64};
        tbl[2] = '{1'b1, 16'd100, 5'b10101, 16'h0000, -1, 0,  0,  1'b0, 164};
        tbl[3] = '{1'b1, 16'd0,   5'b11111, 16'h8000, -1, 1,  15, 1'b1, 64};
        tbl[4] = '{1'b0, 16'd50,  5'b01010, 16'hFFFF, -1, 16, 0,  1'b1, 64};
        tbl[5] = '{1'b1, 16'd1,   5'b00110, 16'h0001, -1, 1,  0,  1'b1, 65};
        tbl[6] = '{1'b0, 16'd0,   5'b00000, 16'h0400, 10, 1,  10, 1'b1, 64};

        load_mem(16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset cut_in", 32'(cut_in), 32'd0);
        check("reset vec_addr", 32'(vec_addr), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i])
            run_check($sformatf("tbl%0d", i), tbl[i].m, tbl[i].len, tbl[i].sv, tbl[i].mask,
                      tbl[i].poke, tbl[i].exp_err, tbl[i].exp_first, tbl[i].exp_flag,
                      tbl[i].exp_lat);

        // random runs against the run-level model
        for (int r = 0; r < 20; r++) begin
            r_m    = 1'($urandom_range(0, 1));
            r_len  = 16'($urandom_range(0, 30));
            r_mask = 16'($urandom) & 16'($urandom);
            e_err = 0; e_first = 0;
            for (int i = VL - 1; i >= 0; i--)
                if (r_mask[i]) begin e_err++; e_first = i; end
            run_check($sformatf("rnd%0d", r), r_m, r_len, 5'($urandom), r_mask, -1,
                      e_err, e_first, (e_err != 0),
                      ((r_m && r_len != 0) ? int'(r_len) : 0) + VL * P);
        end

        // abort at vector 7
        load_mem(16'h0424);
        pulse_start(1'b0, 16'd0, 5'd0);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (vec_addr == 4'd7) begin found = 1; break; end
        end
        check("abort reached_vec7", 32'(found), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort cut_in", 32'(cut_in), 32'd0);
        check("abort err_count", 32'(err_count), 32'd2);
        check("abort first_err_addr", 32'(first_err_addr), 32'd2);
        check("abort err_flag", 32'(err_flag), 32'd1);
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check("abort no_done", 32'(dones), 32'd0);
        check("abort err_held", 32'(err_count), 32'd2);
        run_check("after_abort", 1'b0, 16'd0, 5'd0, 16'h0000, -1, 0, 0, 1'b0, 64);

        // abort coinciding with a mismatch in SAMPLE of vector 0
        load_mem(16'h0001);
        pulse_start(1'b0, 16'd0, 5'd0);
        repeat (ST + 1) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_sample busy", 32'(busy), 32'd0);
        check("abort_sample err_count", 32'(err_count), 32'd1);
        check("abort_sample err_flag", 32'(err_flag), 32'd1);

        // abort and start together in IDLE
        @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check("abort_start busy", 32'(busy), 32'd0);
        check("abort_start err_kept", 32'(err_count), 32'd1);

        // reset asserted in APPLY of vector 5 with one error already counted
        load_mem(16'h0002);
        pulse_start(1'b0, 16'd0, 5'd0);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (vec_addr == 4'd5) begin found = 1; break; end
        end
        @(posedge clk); #1;
        check("rst reached_apply", 32'(found & busy), 32'd1);
        check("rst pre_err", 32'(err_count), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst cut_in", 32'(cut_in), 32'd0);
        check("rst vec_addr", 32'(vec_addr), 32'd0);
        check("rst err_count", 32'(err_count), 32'd0);
        check("rst err_flag", 32'(err_flag), 32'd0);
        check("rst first_err_addr", 32'(first_err_addr), 32'd0);
        check("rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("rst stays_idle", 32'(dones), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
